// File: rtl/bit4_pkg.sv
// Shared definitions for the 4-bit serial loader: state encoding and word width.
package bit4_pkg;

    localparam int WORD_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/bit4_shift_core.sv
// Shift word and bit counter; direction selects which end the new bit enters.
module bit4_shift_core
    import bit4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       dir_i,
    input  logic       sin_i,
    output logic [4:1] word_o,
    output logic [2:0] cnt_o
);

    logic [4:1] word_q, word_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            // The word is deliberately kept so it stays visible after an ack.
            cnt_d = 3'd0;
        end else if (en_i) begin
            word_d = dir_i ? {word_q[3:1], sin_i} : {sin_i, word_q[4:2]};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= 4'b0000;
            cnt_q  <= 3'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bit4_serial_loader.sv
// Serial-to-4-bit loader with valid/ready input, word_valid/ack output and ack counter.
module bit4_serial_loader
    import bit4_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_valid,
    output logic       sin_ready,
    output logic [4:1] word_out,
    output logic       word_valid,
    input  logic       word_ack,
    output logic [2:0] bit_cnt,
    output logic [3:0] word_cnt
);

    state_e     state_q;
    logic [3:0] word_cnt_q;
    logic       accept;
    logic       last_bit;
    logic       ack_take;

    assign sin_ready  = (state_q != ST_FULL);
    assign word_valid = (state_q == ST_FULL);
    assign accept     = sin_valid & sin_ready;
    assign ack_take   = word_valid & word_ack;
    assign last_bit   = accept && (bit_cnt == 3'(WORD_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept)   state_q <= ST_SHIFT;
                ST_SHIFT: if (last_bit) state_q <= ST_FULL;
                ST_FULL: begin
                    if (word_ack) begin
                        state_q    <= ST_IDLE;
                        word_cnt_q <= word_cnt_q + 4'd1;
                    end
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    bit4_shift_core u_core (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .clr_i  (ack_take),
        .dir_i  (MSB_FIRST != 0),
        .sin_i  (sin),
        .word_o (word_out),
        .cnt_o  (bit_cnt)
    );

    assign word_cnt = word_cnt_q;

endmodule
